// File: rtl/bol.sv
// bol: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per edge.
// Define BOL_HIZLI_OZEL_EN to finish divide-by-zero and signed overflow one edge after accept.
module bol #(
  parameter int VERI_GENISLIK = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     basla_i,
  input  logic                     iptal_i,
  input  logic [VERI_GENISLIK-1:0] ilksayi_i,
  input  logic [VERI_GENISLIK-1:0] ikincisayi_i,
  input  logic [1:0]               buyruk_i,
  output logic                     mesgul_o,
  output logic                     gecerli_o,
  output logic [VERI_GENISLIK-1:0] sonuc_o
);
  localparam int W = VERI_GENISLIK;
  localparam logic [W-1:0] EN_KUCUK = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [1:0] {BOS, HESAP, BITTI} durum_t;
  durum_t durum_q, ilk_d;
  logic [4:0] sayac_q;
  logic [W-1:0] kalan_q, bolum_q, bolen_q, ham_q, sonuc_q;
  logic rem_q, bolum_isaret_q, kalan_isaret_q, sifir_q, tasma_q, gecerli_q;
  logic isaretli, a_neg, b_neg, sifir_d, tasma_d;
  logic [W:0] deneme_d, fark_d;
  logic [W-1:0] a_mag, b_mag, bolum_d, kalan_d, sonuc_d;
  always_comb begin
    isaretli = ~buyruk_i[0];
    a_neg = isaretli & ilksayi_i[W-1];
    b_neg = isaretli & ikincisayi_i[W-1];
    a_mag = a_neg ? -ilksayi_i : ilksayi_i;
    b_mag = b_neg ? -ikincisayi_i : ikincisayi_i;
    sifir_d = ikincisayi_i == '0;
    tasma_d = isaretli && ilksayi_i == EN_KUCUK && &ikincisayi_i;
`ifdef BOL_HIZLI_OZEL_EN
    ilk_d = (sifir_d | tasma_d) ? BITTI : HESAP;
`else
    ilk_d = HESAP;
`endif
    // 33-bit trial subtraction: bit W set means the shifted remainder was smaller than the divisor
    deneme_d = {kalan_q, bolum_q[W-1]};
    fark_d = deneme_d - {1'b0, bolen_q};
    bolum_d = bolum_isaret_q ? -bolum_q : bolum_q;
    kalan_d = kalan_isaret_q ? -kalan_q : kalan_q;
    sonuc_d = sifir_q ? (rem_q ? ham_q : '1) :
              tasma_q ? (rem_q ? '0 : EN_KUCUK) :
              rem_q ? kalan_d : bolum_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q <= BOS;
      sayac_q <= '0;
      kalan_q <= '0;
      bolum_q <= '0;
      bolen_q <= '0;
      ham_q <= '0;
      sonuc_q <= '0;
      rem_q <= 1'b0;
      bolum_isaret_q <= 1'b0;
      kalan_isaret_q <= 1'b0;
      sifir_q <= 1'b0;
      tasma_q <= 1'b0;
      gecerli_q <= 1'b0;
    end else begin
      gecerli_q <= 1'b0;
      if (iptal_i) durum_q <= BOS;
      else
        case (durum_q)
          BOS: if (basla_i) begin
            durum_q <= ilk_d;
            sayac_q <= '0;
            kalan_q <= '0;
            bolum_q <= a_mag;
            bolen_q <= b_mag;
            ham_q <= ilksayi_i;
            rem_q <= buyruk_i[1];
            bolum_isaret_q <= a_neg ^ b_neg;
            kalan_isaret_q <= a_neg;
            sifir_q <= sifir_d;
            tasma_q <= tasma_d;
          end
          HESAP: begin
            kalan_q <= fark_d[W] ? deneme_d[W-1:0] : fark_d[W-1:0];
            bolum_q <= {bolum_q[W-2:0], ~fark_d[W]};
            sayac_q <= sayac_q + 5'd1;
            if (sayac_q == 5'd31) durum_q <= BITTI;
          end
          BITTI: begin
            sonuc_q <= sonuc_d;
            gecerli_q <= 1'b1;
            durum_q <= BOS;
          end
          default: durum_q <= BOS;
        endcase
    end
  end
  assign mesgul_o = durum_q != BOS;
  assign gecerli_o = gecerli_q;
  assign sonuc_o = sonuc_q;
endmodule

// File: tb/tb_bol.sv
// tb_bol: scoreboard bench for bol; expected results come from plain integer division with RISC-V special cases.
module tb_bol;
  logic clk_i = 1'b0, rst_ni = 1'b0, basla_i = 1'b0, iptal_i = 1'b0;
  logic [31:0] ilksayi_i = '0, ikincisayi_i = '0;
  logic [1:0] buyruk_i = '0;
  logic mesgul_o, gecerli_o;
  logic [31:0] sonuc_o;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] exp_q[$];
  int due_q[$];
  logic [31:0] last_res = '0;
`ifdef BOL_HIZLI_OZEL_EN
  localparam bit HIZLI = 1'b1;
`else
  localparam bit HIZLI = 1'b0;
`endif

  bol dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .basla_i(basla_i), .iptal_i(iptal_i),
    .ilksayi_i(ilksayi_i), .ikincisayi_i(ikincisayi_i), .buyruk_i(buyruk_i),
    .mesgul_o(mesgul_o), .gecerli_o(gecerli_o), .sonuc_o(sonuc_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] ref_sonuc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? a % b : a / b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int gecikme(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ozel;
    ozel = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (ozel && HIZLI) ? 1 : 33;
  endfunction

  function automatic logic [31:0] sec_sayi();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive between edges; the next rising edge is the accepting edge.
  task automatic kabul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    basla_i = 1'b1;
    buyruk_i = op;
    ilksayi_i = a;
    ikincisayi_i = b;
    @(posedge clk_i);
    #1;
    exp_q.push_back(ref_sonuc(op, a, b));
    due_q.push_back(cyc + gecikme(op, a, b));
    basla_i = 1'b0;
    ilksayi_i = $urandom;
    ikincisayi_i = $urandom;
    buyruk_i = 2'($urandom);
  endtask

  task automatic bekle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (gecerli_o) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout no gecerli_o within 40 cycles");
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic islem(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    kabul(op, a, b);
    bekle();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_i);
        if (gecerli_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid got sonuc %h expected no pulse", sonuc_o);
          end else begin
            logic [31:0] e;
            int d;
            e = exp_q.pop_front();
            d = due_q.pop_front();
            chk("result", sonuc_o, e);
            chk("latency_cycle", 32'(cyc), 32'(d));
            last_res = e;
          end
        end
      end
    join_none
    #3;
    chk("rst_mesgul", {31'b0, mesgul_o}, 32'h0);
    chk("rst_gecerli", {31'b0, gecerli_o}, 32'h0);
    chk("rst_sonuc", sonuc_o, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    islem(2'b01, 32'd100, 32'd7);
    islem(2'b11, 32'd100, 32'd7);
    islem(2'b00, 32'hFFFF_FF9C, 32'd7);
    islem(2'b10, 32'hFFFF_FF9C, 32'd7);
    islem(2'b10, 32'd100, 32'hFFFF_FFF9);
    islem(2'b00, 32'd5, 32'd0);
    islem(2'b10, 32'd5, 32'd0);
    islem(2'b01, 32'd0, 32'd0);
    islem(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    islem(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    islem(2'b11, 32'hFFFF_FFFF, 32'h10);
    islem(2'b10, 32'hFFFF_FFF1, 32'd0);
    // abort 10 edges into the operation
    kabul(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    #1 iptal_i = 1'b1;
    @(posedge clk_i);
    #1 iptal_i = 1'b0;
    void'(exp_q.pop_back());
    void'(due_q.pop_back());
    @(negedge clk_i);
    chk("abort_mesgul", {31'b0, mesgul_o}, 32'h0);
    chk("abort_gecerli", {31'b0, gecerli_o}, 32'h0);
    repeat (40) @(negedge clk_i);
    chk("abort_sonuc_hold", sonuc_o, last_res);
    // abort beats a same-cycle start
    basla_i = 1'b1;
    iptal_i = 1'b1;
    @(posedge clk_i);
    #1;
    basla_i = 1'b0;
    iptal_i = 1'b0;
    @(negedge clk_i);
    chk("abort_blocks_start", {31'b0, mesgul_o}, 32'h0);
    repeat (36) @(negedge clk_i);
    islem(2'b01, 32'd9, 32'd3);
    // start held high while busy: one result only
    kabul(2'b01, 32'd77, 32'd5);
    basla_i = 1'b1;
    repeat (19) @(posedge clk_i);
    #1 basla_i = 1'b0;
    bekle();
    repeat (3) @(negedge clk_i);
    chk("hold_start_idle", {31'b0, mesgul_o}, 32'h0);
    // asynchronous reset mid-operation
    kabul(2'b00, 32'hFFFF_0000, 32'd13);
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_mesgul", {31'b0, mesgul_o}, 32'h0);
    chk("arst_gecerli", {31'b0, gecerli_o}, 32'h0);
    chk("arst_sonuc", sonuc_o, 32'h0);
    exp_q.delete();
    due_q.delete();
    last_res = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      islem(2'($urandom), sec_sayi(), sec_sayi());
    end
    repeat (5) @(negedge clk_i);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
